// File: rtl/muldiv_pkg.sv
// Shared multiply/divide definitions: operand width, divide opcodes, divider
// states and the RISC-V special-case result constants.
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_e;

    localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = '1;
    localparam logic [XLEN-1:0] SIGNED_MIN    = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/iter_divider_32bit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU with valid/ready request and
// one-cycle response pulse. Define DIV_EARLY_OUT_EN to finish |a| < |b| in one cycle.
module iter_divider_32bit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      div_opcode,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            flush,
    output logic            busy,
    output logic            resp_valid,
    output logic [XLEN-1:0] result_divide
);

    localparam int unsigned REM_W = XLEN + 1;

    div_state_e       state, state_d;
    div_op_e          op_q;
    logic             q_neg, r_neg;
    logic [XLEN-1:0]  div_q;
    logic [XLEN-1:0]  quo;
    logic [REM_W-1:0] rem;
    logic [CNT_W-1:0] cnt;

    div_op_e          op_c;
    logic             signed_c, a_neg_c, b_neg_c, accept_c;
    logic             div0_c, ovf_c, early_c, special_c;
    logic [XLEN-1:0]  a_mag_c, b_mag_c, special_res_c, fix_res_c, q_fix_c, r_fix_c;
    logic [REM_W:0]   rem_sh_c, trial_c;
    logic             borrow_c;
    logic [REM_W-1:0] rem_next_c;
    logic [XLEN-1:0]  quo_next_c;

    // Handshake; busy also covers the accept cycle itself.
    assign req_ready  = (state == IDLE) || (state == DONE);
    assign busy       = !req_ready || (req_valid && req_ready);
    assign resp_valid = (state == DONE) && !flush;
    assign accept_c   = req_valid && req_ready && !flush;

    // Operand decode and special-case detection on the incoming request.
    always_comb begin
        op_c     = div_op_e'(div_opcode);
        signed_c = (op_c == DIV_OP_DIV) || (op_c == DIV_OP_REM);
        a_neg_c  = signed_c && operand1[XLEN-1];
        b_neg_c  = signed_c && operand2[XLEN-1];
        a_mag_c  = a_neg_c ? XLEN'(-operand1) : operand1;
        b_mag_c  = b_neg_c ? XLEN'(-operand2) : operand2;
        div0_c   = (operand2 == '0);
        ovf_c    = signed_c && (operand1 == SIGNED_MIN) && (operand2 == DIV_BY_ZERO_Q);
`ifdef DIV_EARLY_OUT_EN
        early_c  = !div0_c && (a_mag_c < b_mag_c);
`else
        early_c  = 1'b0;
`endif
        special_c = div0_c || ovf_c || early_c;
        if (div0_c) begin
            special_res_c = (op_c == DIV_OP_REM || op_c == DIV_OP_REMU) ? operand1 : DIV_BY_ZERO_Q;
        end else if (ovf_c) begin
            special_res_c = (op_c == DIV_OP_REM) ? '0 : SIGNED_MIN;
        end else begin
            special_res_c = (op_c == DIV_OP_REM || op_c == DIV_OP_REMU) ? operand1 : '0;
        end
    end

    // One restoring step plus the final sign fix-up.
    always_comb begin
        rem_sh_c   = {rem, quo[XLEN-1]};
        trial_c    = rem_sh_c - (REM_W+1)'(div_q);
        borrow_c   = trial_c[REM_W];
        rem_next_c = borrow_c ? REM_W'(rem_sh_c) : REM_W'(trial_c);
        quo_next_c = {quo[XLEN-2:0], !borrow_c};
        q_fix_c    = q_neg ? XLEN'(-quo) : quo;
        r_fix_c    = r_neg ? XLEN'(-rem) : XLEN'(rem);
        fix_res_c  = (op_q == DIV_OP_REM || op_q == DIV_OP_REMU) ? r_fix_c : q_fix_c;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept_c) state_d = special_c ? DONE : CALC;
            end
            CALC:    if (cnt == '0) state_d = FIX;
            FIX:     state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q          <= DIV_OP_DIV;
            q_neg         <= 1'b0;
            r_neg         <= 1'b0;
            div_q         <= '0;
            quo           <= '0;
            rem           <= '0;
            cnt           <= '0;
            result_divide <= '0;
        end else if (accept_c) begin
            op_q  <= op_c;
            q_neg <= a_neg_c ^ b_neg_c;
            r_neg <= a_neg_c;
            div_q <= b_mag_c;
            quo   <= a_mag_c;
            rem   <= '0;
            cnt   <= CNT_W'(XLEN - 1);
            if (special_c) result_divide <= special_res_c;
        end else if (state == CALC) begin
            quo <= quo_next_c;
            rem <= rem_next_c;
            cnt <= cnt - CNT_W'(1);
        end else if (state == FIX && !flush) begin
            result_divide <= fix_res_c;
        end
    end

endmodule

// File: tb/tb_iter_divider_32bit.sv
// Self-checking bench for iter_divider_32bit: directed cases plus randomized
// operations compared against a plain-arithmetic RISC-V division model.
module tb_iter_divider_32bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  div_opcode;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        flush;
    logic        busy;
    logic        resp_valid;
    logic [31:0] result_divide;

    int n_checks = 0;
    int n_errors = 0;

    iter_divider_32bit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .div_opcode(div_opcode), .operand1(operand1), .operand2(operand2),
        .flush(flush), .busy(busy), .resp_valid(resp_valid),
        .result_divide(result_divide)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [31:0] q, r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0;
        end else if (!op[0]) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = a / b; r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] am, bm;
        am = (!op[0] && a[31]) ? -a : a;
        bm = (!op[0] && b[31]) ? -b : b;
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (am < bm) return 1;
`else
        if (am < bm) return 34;
`endif
        return 34;
    endfunction

    // Drives one request and returns cycles from accept to resp_valid plus the result.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res);
        @(negedge clk);
        req_valid = 1'b1; div_opcode = op; operand1 = a; operand2 = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result_divide;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; flush = 1'b0;
        div_opcode = 2'b00; operand1 = '0; operand2 = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (resp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        n_checks++; if (result_divide !== 32'd0) begin n_errors++; $display("FAIL reset_result: got %h expected 0", result_divide); end
        rst = 1'b0;
    endtask

    task automatic test_signed();
        int lat; logic [31:0] res;
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, lat, res);
        n_checks++; if (lat !== 34) begin n_errors++; $display("FAIL div_neg_latency: got %0d expected 34", lat); end
        n_checks++; if (res !== 32'hFFFF_FFFD) begin n_errors++; $display("FAIL div_neg_result: got %h expected fffffffd", res); end
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, res);
        n_checks++; if (res !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL rem_neg_result: got %h expected ffffffff", res); end
    endtask

    task automatic test_unsigned_busy();
        int lat, busy_cycles; logic [31:0] res;
        run_op(2'b11, 32'hFFFF_FFFF, 32'h10, lat, res);
        n_checks++; if (res !== 32'h0000_000F) begin n_errors++; $display("FAIL remu_result: got %h expected 0000000f", res); end
        @(negedge clk);
        req_valid = 1'b1; div_opcode = 2'b01; operand1 = 32'hFFFF_FFFF; operand2 = 32'h10;
        #1;
        busy_cycles = busy ? 1 : 0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin
            if (busy) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
        n_checks++; if (lat !== 34) begin n_errors++; $display("FAIL divu_latency: got %0d expected 34", lat); end
        n_checks++; if (result_divide !== 32'h0FFF_FFFF) begin n_errors++; $display("FAIL divu_result: got %h expected 0fffffff", result_divide); end
        n_checks++; if (busy_cycles !== 34) begin n_errors++; $display("FAIL divu_busy_span: got %0d expected 34", busy_cycles); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL divu_busy_done: got %b expected 0", busy); end
        @(posedge clk); #1;
        n_checks++; if (resp_valid !== 1'b0) begin n_errors++; $display("FAIL resp_pulse_width: got %b expected 0", resp_valid); end
    endtask

    task automatic test_special();
        int lat; logic [31:0] res;
        run_op(2'b00, 32'd5, 32'd0, lat, res);
        n_checks++; if (lat !== 1) begin n_errors++; $display("FAIL div0_latency: got %0d expected 1", lat); end
        n_checks++; if (res !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL div0_result: got %h expected ffffffff", res); end
        run_op(2'b11, 32'd5, 32'd0, lat, res);
        n_checks++; if (res !== 32'd5) begin n_errors++; $display("FAIL remu0_result: got %h expected 00000005", res); end
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
        n_checks++; if (lat !== 1) begin n_errors++; $display("FAIL ovf_latency: got %0d expected 1", lat); end
        n_checks++; if (res !== 32'h8000_0000) begin n_errors++; $display("FAIL ovf_div_result: got %h expected 80000000", res); end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
        n_checks++; if (res !== 32'd0) begin n_errors++; $display("FAIL ovf_rem_result: got %h expected 0", res); end
    endtask

    // Abandons a DIV 100/7 at T0+10 using either flush or rst.
    task automatic test_abort(input bit use_rst);
        logic [31:0] prev;
        int pulses;
        prev = result_divide;
        @(negedge clk);
        req_valid = 1'b1; div_opcode = 2'b00; operand1 = 32'd100; operand2 = 32'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0;
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL abort%0d_req_ready: got %b expected 1", use_rst, req_ready); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL abort%0d_busy: got %b expected 0", use_rst, busy); end
        n_checks++; if (result_divide !== (use_rst ? 32'd0 : prev)) begin n_errors++; $display("FAIL abort%0d_result: got %h expected %h", use_rst, result_divide, use_rst ? 32'd0 : prev); end
        pulses = 0;
        repeat (40) begin
            if (resp_valid) pulses++;
            @(posedge clk); #1;
        end
        n_checks++; if (pulses !== 0) begin n_errors++; $display("FAIL abort%0d_no_resp: got %0d pulses expected 0", use_rst, pulses); end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        req_valid = 1'b1; div_opcode = 2'b01; operand1 = 32'd100; operand2 = 32'd7;
        @(posedge clk); #1;
        div_opcode = 2'b11;
        lat = 1;
        while (!resp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        n_checks++; if (lat !== 34) begin n_errors++; $display("FAIL b2b_first_latency: got %0d expected 34", lat); end
        n_checks++; if (result_divide !== 32'hE) begin n_errors++; $display("FAIL b2b_first_result: got %h expected 0000000e", result_divide); end
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready_in_done: got %b expected 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        n_checks++; if (lat !== 34) begin n_errors++; $display("FAIL b2b_second_latency: got %0d expected 34", lat); end
        n_checks++; if (result_divide !== 32'h2) begin n_errors++; $display("FAIL b2b_second_result: got %h expected 00000002", result_divide); end
    endtask

    task automatic test_early_out();
        int lat, exp_lat; logic [31:0] res;
`ifdef DIV_EARLY_OUT_EN
        exp_lat = 1;
`else
        exp_lat = 34;
`endif
        run_op(2'b01, 32'd3, 32'd10, lat, res);
        n_checks++; if (lat !== exp_lat) begin n_errors++; $display("FAIL early_divu_latency: got %0d expected %0d", lat, exp_lat); end
        n_checks++; if (res !== 32'd0) begin n_errors++; $display("FAIL early_divu_result: got %h expected 0", res); end
        run_op(2'b10, 32'hFFFF_FFFD, 32'd10, lat, res);
        n_checks++; if (lat !== exp_lat) begin n_errors++; $display("FAIL early_rem_latency: got %0d expected %0d", lat, exp_lat); end
        n_checks++; if (res !== 32'hFFFF_FFFD) begin n_errors++; $display("FAIL early_rem_result: got %h expected fffffffd", res); end
    endtask

    task automatic test_random();
        int lat; logic [31:0] res, a, b; logic [1:0] op;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 15));
                2: b = $urandom >> $urandom_range(0, 31);
                3: b = (i % 3 == 0) ? 32'd0 : 32'hFFFF_FFFF;
                default: begin b = $urandom; a = b >> $urandom_range(1, 4); end
            endcase
            run_op(op, a, b, lat, res);
            n_checks++; if (res !== ref_div(op, a, b)) begin n_errors++; $display("FAIL rand%0d_result op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, res, ref_div(op, a, b)); end
            n_checks++; if (lat !== ref_lat(op, a, b)) begin n_errors++; $display("FAIL rand%0d_latency op=%0d a=%h b=%h: got %0d expected %0d", i, op, a, b, lat, ref_lat(op, a, b)); end
        end
    endtask

    initial begin
        test_reset();
        test_signed();
        test_unsigned_busy();
        test_special();
        test_abort(1'b0);
        test_abort(1'b1);
        test_back_to_back();
        test_early_out();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
